// File: rtl/output_pipeline.sv
// output_pipeline: maps each m1 image pixel through the m3 equalization table and writes packed words to m4
module output_pipeline #(
   parameter logic [15:0] LAST_WORD_ADDR = 16'd3,
   parameter logic [15:0] MAP_TAG        = 16'hAAAA
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         start,
   input  logic         inputBaseOffset,
   output logic [15:0]  m1ReadAddr,
   input  logic [127:0] m1ReadBus,
   output logic [15:0]  m3ReadAddr,
   input  logic [127:0] m3ReadBus,
   output logic [15:0]  m4WriteAddr,
   output logic [127:0] m4WriteBus,
   output logic         m4WE,
   output logic         done,
   output logic         mapError
);
   typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;
   state_t state, state_next;
   logic [3:0]   byte_index;
   logic [15:0]  word_counter;
   logic         lk_valid;
   logic [3:0]   lk_lane;
   logic [15:0]  lk_addr;
   logic [127:0] asm_word;
   logic         last_byte, last_word, advance, tag_ok;
   logic [7:0]   pixel, mapped;
   logic         unused_m3;
   assign unused_m3  = ^m3ReadBus[127:36] ^ ^m3ReadBus[19:8];
   assign last_byte  = byte_index == 4'd15;
   assign last_word  = word_counter == LAST_WORD_ADDR;
   assign advance    = state == RUN && last_byte && !last_word;
   assign pixel      = m1ReadBus[{byte_index, 3'b000} +: 8];
   assign tag_ok     = m3ReadBus[35:20] == MAP_TAG;
   assign mapped     = tag_ok ? m3ReadBus[7:0] : 8'h00;
   assign m1ReadAddr = advance ? word_counter + 16'd1 : word_counter;
   assign m3ReadAddr = state == RUN ? {inputBaseOffset, 7'b0000000, pixel} : 16'h0000;
   assign done       = state == DONE;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = PRIME;
         PRIME:   state_next = RUN;
         RUN:     state_next = last_byte && last_word ? DRAIN : RUN;
         DRAIN:   state_next = byte_index == 4'd1 ? DONE : DRAIN;
         default: state_next = DONE;
      endcase
      if (!start) state_next = IDLE;
   end
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   // lookup stage tracks the pixel whose table entry arrives next cycle; pack stage assembles it
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n || !start) begin
         byte_index   <= 4'd0;
         word_counter <= 16'd0;
         lk_valid     <= 1'b0;
         lk_lane      <= 4'd0;
         lk_addr      <= 16'd0;
         asm_word     <= '0;
         m4WriteAddr  <= 16'd0;
         m4WriteBus   <= '0;
         m4WE         <= 1'b0;
         mapError     <= 1'b0;
      end else begin
         byte_index   <= (state == RUN || state == DRAIN) ? byte_index + 4'd1 : byte_index;
         word_counter <= advance ? word_counter + 16'd1 : word_counter;
         lk_valid     <= state == RUN;
         lk_lane      <= byte_index;
         lk_addr      <= word_counter;
         m4WE         <= 1'b0;
         if (lk_valid) begin
            asm_word[{lk_lane, 3'b000} +: 8] <= mapped;
            if (!tag_ok) mapError <= 1'b1;
            if (lk_lane == 4'd15) begin
               m4WE        <= 1'b1;
               m4WriteAddr <= lk_addr;
               m4WriteBus  <= {mapped, asm_word[119:0]};
            end
         end
      end
   end
endmodule
